// File: rtl/pulse_sync_arb.sv
// pulse_sync_arb: clka-side scheduler sharing one pulse_sync channel among N
// requesters. Events are queued as pending flags, granted one at a time, and
// each issued pulse is followed by a guard gap of GAP low cycles on a_pul.
// Optional build macro PULSE_SYNC_ARB_PRIO_EN switches round-robin arbitration
// to fixed priority (lowest index wins, no pointer).
//
// Handshake note: there is no back-pressure. A req[i] high cycle is one
// event; a second event while pend[i] is still held (and not being cleared
// on that edge) is dropped and recorded in the sticky ovf[i].
module pulse_sync_arb #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int GAP = 4
) (
  input  logic           clka,
  input  logic           rsta,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   ovf_clr,
  output logic           a_pul,
  output logic [IDW-1:0] a_id,
  output logic           busy,
  output logic [N-1:0]   pend,
  output logic [N-1:0]   ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           a_pul_q, a_pul_d;
  logic [IDW-1:0] a_id_q, a_id_d;
  logic [7:0]     gap_q, gap_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   ovf_q, ovf_d;
  logic [N-1:0]   clr;
  logic [IDW-1:0] start;
  logic [N-1:0]   rot;
  logic           win_vld;
  logic [IDW:0]   win_off;
  logic [IDW:0]   win_sum;
  logic [IDW-1:0] win_idx;

`ifdef PULSE_SYNC_ARB_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign start = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`endif

  // Winner select: rotate pend so the scan start sits at bit 0, find the
  // lowest set bit, then map the offset back to an index modulo N.
  always_comb begin
    rot     = N'({pend_q, pend_q} >> start);
    win_vld = 1'b0;
    win_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_vld = 1'b1;
        win_off = (IDW+1)'(k);
      end
    end
    win_sum = {1'b0, start} + win_off;
    if (win_sum >= (IDW+1)'(N)) win_sum = win_sum - (IDW+1)'(N);
    win_idx = win_sum[IDW-1:0];
  end

  // Event capture: a new event beats a grant clear on the same edge; a
  // dropped event sets ovf, and a set beats ovf_clr on the same edge.
  always_comb begin
    clr = '0;
    for (int k = 0; k < N; k++) begin
      clr[k] = (state_q == ST_FIRE) && (a_id_q == IDW'(k));
    end
    pend_d = req | (pend_q & ~clr);
    ovf_d  = (req & pend_q & ~clr) | (ovf_q & ~ovf_clr);
  end

  // Scheduler FSM next state: IDLE -> FIRE (1 cycle) -> GAP (GAP cycles),
  // then straight back to FIRE if anything is pending.
  always_comb begin
    state_d = state_q;
    a_id_d  = a_id_q;
    gap_d   = gap_q;
`ifndef PULSE_SYNC_ARB_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_FIRE;
          a_id_d  = win_idx;
        end
      end
      ST_FIRE: begin
        state_d = ST_GAP;
        gap_d   = 8'(GAP);
`ifndef PULSE_SYNC_ARB_PRIO_EN
        ptr_d   = (a_id_q == IDW'(N - 1)) ? '0 : a_id_q + IDW'(1);
`endif
      end
      ST_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d = '0;
          if (win_vld) begin
            state_d = ST_FIRE;
            a_id_d  = win_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    a_pul_d = (state_d == ST_FIRE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= ST_IDLE;
      a_pul_q <= 1'b0;
      a_id_q  <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
`ifndef PULSE_SYNC_ARB_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_pul_q <= a_pul_d;
      a_id_q  <= a_id_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
`ifndef PULSE_SYNC_ARB_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign a_pul = a_pul_q;
  assign a_id  = a_id_q;
  assign busy  = (state_q != ST_IDLE);
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pulse_sync_arb.sv
// Bench for pulse_sync_arb: directed scenario tasks plus randomized traffic,
// with a time-based reference model (last-fire timestamp, gap window) and an
// expected-id queue for every issued pulse.
`timescale 1ns/1ps
module tb_pulse_sync_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int GAP = 4;

  // Clock/reset block
  logic           clka = 1'b0;
  logic           rsta = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   ovf_clr = '0;
  logic           a_pul;
  logic [IDW-1:0] a_id;
  logic           busy;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovf;

  int checks = 0;
  int failures = 0;

  always #5 clka = ~clka;

  pulse_sync_arb #(.N(N), .IDW(IDW), .GAP(GAP)) dut (
    .clka(clka), .rsta(rsta), .req(req), .ovf_clr(ovf_clr),
    .a_pul(a_pul), .a_id(a_id), .busy(busy), .pend(pend), .ovf(ovf)
  );

  // Reference model: one update per clka edge from the sampled inputs.
  bit             m_valid = 1'b0;
  int             edge_n = 0;
  int             last_fire = -1000;
  int             m_ptr = 0;
  int             w;
  int             idx;
  logic [N-1:0]   m_pend = '0, m_ovf = '0, old_pend, clear, dropped;
  logic           m_pul = 1'b0, m_busy = 1'b0;
  logic [IDW-1:0] m_id = '0;
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] exp_v;
  logic           prev_pul = 1'b0;

  always @(posedge clka) begin
    edge_n++;
    if (rsta) begin
      m_valid   = 1'b1;
      m_pend    = '0;
      m_ovf     = '0;
      m_pul     = 1'b0;
      m_id      = '0;
      m_busy    = 1'b0;
      m_ptr     = 0;
      last_fire = -1000;
      exp_q.delete();
    end else if (m_valid) begin
      old_pend = m_pend;
      clear    = '0;
      if (edge_n == last_fire + 1) clear[m_id] = 1'b1;
      dropped  = req & old_pend & ~clear;
      m_pend   = req | (old_pend & ~clear);
      m_ovf    = dropped | (m_ovf & ~ovf_clr);
      m_pul    = 1'b0;
      if (edge_n >= last_fire + GAP + 1 && old_pend != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
`ifdef PULSE_SYNC_ARB_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % N;
`endif
          if (w < 0 && old_pend[idx]) w = idx;
        end
        m_id      = IDW'(w);
        m_pul     = 1'b1;
        last_fire = edge_n;
        m_ptr     = (w + 1) % N;
        exp_q.push_back(IDW'(w));
      end
      m_busy = (edge_n <= last_fire + GAP);
    end
  end

  // Scoreboard: compare every cycle away from the active edge.
  always @(negedge clka) begin
    if (m_valid) begin
      checks++;
      if (a_pul !== m_pul) begin
        failures++;
        $display("FAIL model_a_pul t=%0t got=%b exp=%b", $time, a_pul, m_pul);
      end
      checks++;
      if (a_id !== m_id) begin
        failures++;
        $display("FAIL model_a_id t=%0t got=%0d exp=%0d", $time, a_id, m_id);
      end
      checks++;
      if (busy !== m_busy) begin
        failures++;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
      checks++;
      if (pend !== m_pend) begin
        failures++;
        $display("FAIL model_pend t=%0t got=%b exp=%b", $time, pend, m_pend);
      end
      checks++;
      if (ovf !== m_ovf) begin
        failures++;
        $display("FAIL model_ovf t=%0t got=%b exp=%b", $time, ovf, m_ovf);
      end
      if (a_pul === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_a_id t=%0t got=%0d exp=none", $time, a_id);
        end else begin
          exp_v = exp_q.pop_front();
          if (a_id !== exp_v) begin
            failures++;
            $display("FAIL sb_a_id t=%0t got=%0d exp=%0d", $time, a_id, exp_v);
          end
        end
        checks++;
        if (prev_pul === 1'b1) begin
          failures++;
          $display("FAIL adjacent_pul t=%0t got=11 exp=not_adjacent", $time);
        end
      end
    end
    prev_pul = a_pul;
  end

  // Driver: apply inputs for the next edge, return at the following negedge.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] c, input logic rs);
    req = r;
    ovf_clr = c;
    rsta = rs;
    @(negedge clka);
  endtask

  task automatic test_reset();
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    checks++;
    if ({a_pul, a_id, busy, pend, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b_%0d_%b_%b_%b exp=all_zero", a_pul, a_id, busy, pend, ovf);
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int pul_cnt = 0;
    drive('0, '0, 1'b1);
    drive(4'b0001, '0, 1'b0);
    checks++;
    if (pend !== 4'b0001 || a_pul !== 1'b0) begin
      failures++;
      $display("FAIL single_capture got=pend %b pul %b exp=pend 0001 pul 0", pend, a_pul);
    end
    for (int i = 0; i < 12; i++) begin
      drive('0, '0, 1'b0);
      if (busy === 1'b1) busy_cnt++;
      if (a_pul === 1'b1) pul_cnt++;
      if (i == 0) begin
        checks++;
        if (a_pul !== 1'b1 || a_id !== 2'd0) begin
          failures++;
          $display("FAIL single_latency got=pul %b id %0d exp=pul 1 id 0", a_pul, a_id);
        end
      end
      if (i == 1) begin
        checks++;
        if (pend !== 4'b0000 || a_pul !== 1'b0) begin
          failures++;
          $display("FAIL single_clear got=pend %b pul %b exp=pend 0000 pul 0", pend, a_pul);
        end
      end
    end
    checks++;
    if (busy_cnt != GAP + 1 || pul_cnt != 1) begin
      failures++;
      $display("FAIL single_busy got=busy %0d pulses %0d exp=busy %0d pulses 1", busy_cnt, pul_cnt, GAP + 1);
    end
  endtask

  task automatic test_all_four();
    int ids[$];
    int tms[$];
    drive('0, '0, 1'b1);
    drive(4'b1111, '0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive('0, '0, 1'b0);
      if (a_pul === 1'b1) begin
        ids.push_back(int'(a_id));
        tms.push_back(i);
      end
    end
    checks++;
    if (ids.size() != 4) begin
      failures++;
      $display("FAIL all4_count got=%0d exp=4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ids[k] != k) begin
          failures++;
          $display("FAIL all4_id%0d got=%0d exp=%0d", k, ids[k], k);
        end
        if (k > 0) begin
          checks++;
          if (tms[k] - tms[k-1] != GAP + 1) begin
            failures++;
            $display("FAIL all4_spacing%0d got=%0d exp=%0d", k, tms[k] - tms[k-1], GAP + 1);
          end
        end
      end
    end
    checks++;
    if (ovf !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL all4_end got=ovf %b busy %b exp=ovf 0000 busy 0", ovf, busy);
    end
  endtask

  task automatic test_overflow();
    int g2 = 0;
    int g0 = 0;
    drive('0, '0, 1'b1);
    drive(4'b0101, '0, 1'b0);
    drive(4'b0100, '0, 1'b0);
    drive(4'b0000, '0, 1'b0);
    drive(4'b0100, '0, 1'b0);
    drive(4'b0000, '0, 1'b0);
    drive(4'b0100, '0, 1'b0);
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=0100", ovf);
    end
    for (int i = 0; i < 30; i++) begin
      drive('0, '0, 1'b0);
      if (a_pul === 1'b1 && a_id === 2'd2) g2++;
      if (a_pul === 1'b1 && a_id === 2'd0) g0++;
    end
    checks++;
    if (g2 != 1 || g0 != 0) begin
      failures++;
      $display("FAIL ovf_grants got=g2 %0d g0 %0d exp=g2 1 g0 0", g2, g0);
    end
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=0100", ovf);
    end
    drive('0, 4'b0100, 1'b0);
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0000", ovf);
    end
  endtask

  task automatic test_same_edge();
    drive('0, '0, 1'b1);
    drive(4'b0010, '0, 1'b0);
    drive(4'b0000, '0, 1'b0);
    checks++;
    if (a_pul !== 1'b1 || a_id !== 2'd1) begin
      failures++;
      $display("FAIL same_fire got=pul %b id %0d exp=pul 1 id 1", a_pul, a_id);
    end
    drive(4'b0010, '0, 1'b0);
    checks++;
    if (pend !== 4'b0010 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL same_setwins got=pend %b ovf %b exp=pend 0010 ovf 0000", pend, ovf);
    end
    for (int i = 0; i < GAP; i++) drive('0, '0, 1'b0);
    checks++;
    if (a_pul !== 1'b1 || a_id !== 2'd1) begin
      failures++;
      $display("FAIL same_second got=pul %b id %0d exp=pul 1 id 1", a_pul, a_id);
    end
    for (int i = 0; i < 8; i++) drive('0, '0, 1'b0);
  endtask

  task automatic test_mid_reset();
    drive('0, '0, 1'b1);
    drive(4'b0001, '0, 1'b0);
    drive(4'b0001, '0, 1'b0);
    checks++;
    if (a_pul !== 1'b1 || ovf !== 4'b0001) begin
      failures++;
      $display("FAIL mid_pre got=pul %b ovf %b exp=pul 1 ovf 0001", a_pul, ovf);
    end
    drive(4'b0000, '0, 1'b0);
    drive(4'b0110, '0, 1'b0);
    checks++;
    if (pend !== 4'b0110 || busy !== 1'b1 || a_pul !== 1'b0) begin
      failures++;
      $display("FAIL mid_gap got=pend %b busy %b pul %b exp=pend 0110 busy 1 pul 0", pend, busy, a_pul);
    end
    drive('0, '0, 1'b1);
    checks++;
    if ({a_pul, a_id, busy, pend, ovf} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b_%0d_%b_%b_%b exp=all_zero", a_pul, a_id, busy, pend, ovf);
    end
    drive(4'b1001, '0, 1'b0);
    drive(4'b0000, '0, 1'b0);
    checks++;
    if (a_pul !== 1'b1 || a_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_ptr0 got=pul %b id %0d exp=pul 1 id 0", a_pul, a_id);
    end
    for (int i = 0; i < 15; i++) drive('0, '0, 1'b0);
  endtask

  task automatic test_arb_pattern();
    int n = 0;
    int prev = -1;
    int bad = 0;
    logic [N-1:0] r;
    drive('0, '0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      r = '0;
      if (pend[0] !== 1'b1) r[0] = 1'b1;
      if (pend[3] !== 1'b1) r[3] = 1'b1;
      drive(r, '0, 1'b0);
      if (a_pul === 1'b1) begin
        n++;
`ifdef PULSE_SYNC_ARB_PRIO_EN
        if (a_id !== 2'd0) bad++;
`else
        if ((a_id !== 2'd0 && a_id !== 2'd3) || int'(a_id) == prev) bad++;
`endif
        prev = int'(a_id);
      end
    end
    checks++;
    if (bad != 0 || n < 8) begin
      failures++;
      $display("FAIL arb_pattern got=bad %0d pulses %0d exp=bad 0 pulses>=8", bad, n);
    end
    for (int i = 0; i < 20; i++) drive('0, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] r, c;
    drive('0, '0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < N; k++) begin
        r[k] = ($urandom_range(0, 5) == 0);
        c[k] = ($urandom_range(0, 15) == 0);
      end
      drive(r, c, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 40; i++) drive('0, '0, 1'b0);
    checks++;
    if (busy !== 1'b0 || pend !== 4'b0000) begin
      failures++;
      $display("FAIL random_drain got=busy %b pend %b exp=busy 0 pend 0000", busy, pend);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_queue got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_overflow();
    test_same_edge();
    test_mid_reset();
    test_arb_pattern();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_sync_arb.md
Name: pulse_sync_arb

Overview:
- Source-domain (clka) scheduler that shares one pulse_sync channel among N requesters.
- Each requester raises single-cycle event pulses. The block queues them, grants one at a time by round-robin, and drives a_pul into pulse_sync with a sideband ID.
- After every issued pulse it enforces a guard gap, so pulse_sync never sees pulses closer together than it can carry across to clkb.

Parameters:
- N, 4: number of requesters, 2..16.
- IDW, 2: width of a_id, ceil(log2(N)).
- GAP, 4: minimum number of low cycles on a_pul after each issued pulse, 1..255.

Ports:
- clka  in  1  source-domain clock.
- rsta  in  1  synchronous active-high reset.
- req  in  N  per-requester event pulse; each high cycle is one event.
- ovf_clr  in  N  per-requester clear of the sticky ovf bit.
- a_pul  out  1  pulse into pulse_sync; registered, exactly 1 cycle wide.
- a_id  out  IDW  index of the requester being served; registered.
- busy  out  1  high in FIRE or GAP.
- pend  out  N  pending event flags.
- ovf  out  N  sticky flags: an event was dropped.

Behaviour:
- Reset: one clka cycle with rsta high clears everything. All outputs go to 0, the FSM goes to IDLE, the RR pointer goes to 0 and the gap counter goes to 0. This applies mid-operation too: an in-flight a_pul drops at that edge and the gap is abandoned.
- Event capture: req[i] high at an edge sets pend[i] at that edge.
  - If pend[i] is already 1 and is not being cleared at that edge, the event is dropped and ovf[i] is set.
  - If req[i] arrives at the same edge that pend[i] is cleared by a grant, pend[i] stays 1 (set wins) and no overflow is flagged.
- ovf[i]: sticky, cleared by ovf_clr[i]. If an overflow and ovf_clr[i] occur at the same edge, the set wins.
- FSM states: IDLE, FIRE, GAP.
  - IDLE: if pend is nonzero, pick the winner, latch a_id = winner and go to FIRE. Otherwise stay in IDLE.
  - FIRE: lasts 1 cycle, with a_pul = 1. At its exit edge:
    - clear pend[a_id];
    - pointer = (a_id + 1) mod N;
    - load the gap counter with GAP;
    - go to GAP.
  - GAP: a_pul = 0 and the counter decrements each cycle. When the counter reaches 1:
    - if pend is nonzero, pick the next winner and go straight to FIRE;
    - otherwise go to IDLE.
- Arbitration: round-robin. The winner is the first set pend bit scanning from the pointer upward, wrapping at N-1 to 0.
- Timing:
  - a_pul is never high in two adjacent cycles.
  - Rising edges of a_pul are at least GAP+1 cycles apart. Under continuous load the spacing is exactly GAP+1.
  - a_id changes only on the edge entering FIRE, and holds from FIRE through the end of GAP.
- Latency: req[i] sampled at edge k with the FSM in IDLE gives pend[i] = 1 after edge k and a_pul = 1 after edge k+1, i.e. 2 cycles.
- busy = (state != IDLE).
- Out-of-range requesters: none exist, because the pend width is N. The pointer wraps modulo N, so non-power-of-2 N is legal.

Optional Feature:
- Macro: PULSE_SYNC_ARB_PRIO_EN.
- Defined:
  - Arbitration is fixed priority: the lowest index wins.
  - The RR pointer is removed.
  - Starvation of high indices is permitted.
- Undefined: round-robin arbitration as described in Behaviour.
- Timing, gap, overflow and reset behaviour are identical in both builds.

Test Plan:
- Reset then req = 4'b0001 for 1 cycle -> a_pul high exactly 1 cycle, 2 cycles after req; a_id = 0; pend = 0 after FIRE; busy high for 5 cycles (FIRE + 4 GAP).
- req = 4'b1111 in one cycle -> 4 a_pul pulses 5 cycles apart; a_id sequence 0,1,2,3; ovf = 0; IDLE after the last gap.
- req[2] pulsed 3 times while pend[2] = 1 and the channel is busy serving 0 -> only one extra grant to 2; ovf[2] = 1 until ovf_clr[2] is pulsed, then 0.
- req[1] pulsed on the exact FIRE cycle of requester 1 -> pend[1] stays 1; a second a_id = 1 pulse appears 5 cycles later; ovf[1] = 0.
- rsta asserted in the middle of GAP with pend = 4'b0110 -> next cycle: a_pul = 0, a_id = 0, pend = 0, busy = 0, ovf = 0; the next grant after reset starts from pointer 0.
- PULSE_SYNC_ARB_PRIO_EN defined, req[3] and req[0] repeatedly pending -> a_id is always 0 while pend[0] is set; 3 is served only when pend[0] = 0. Undefined: 0 and 3 alternate.
